fir_serializer: RTL and testbench

FIR_SERIALIZER -- requirements
Module: fir_serializer

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_serializer_if.sv | 25 ++
 rtl/fir_serializer_ctrl.sv | 56 +++++
 rtl/fir_serializer.sv | 58 +++++
 tb/tb_fir_serializer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared width default, frame length and FSM encoding for fir_serializer
package fir_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAME_LEN = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_LOW = 2'd1,
    S_HI  = 2'd2,
    S_SEL = 2'd3
  } state_t;

endpackage

// File: rtl/fir_serializer_if.sv
// rtl/fir_serializer_if.sv - frame load and serial output handshake bundle
interface fir_serializer_if #(
  parameter int WIDTH = fir_pkg::WIDTH_DEF
) ();

  logic [WIDTH-1:0] Low_data_in;
  logic [WIDTH-1:0] Hi_data_in;
  logic [WIDTH-1:0] select_in;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport slave (
    input  Low_data_in, Hi_data_in, select_in, load_valid, data_ready,
    output load_ready, data_out, data_valid
  );

  modport master (
    output Low_data_in, Hi_data_in, select_in, load_valid, data_ready,
    input  load_ready, data_out, data_valid
  );

endinterface

// File: rtl/fir_serializer_ctrl.sv
// rtl/fir_serializer_ctrl.sv - word sequencing FSM, end-of-frame pulse and frame counter
module fir_serializer_ctrl
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load_valid,
  input  logic       data_ready,
  output state_t     state,
  output logic       load_ready,
  output logic       load_fire,
  output logic       data_valid,
  output logic       flags,
  output logic [7:0] frame_cnt
);

  state_t state_q;
  state_t state_d;
  logic   out_fire;
  logic   sel_fire;

  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      flags     <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      // sel_fire is already gated by enable, so the pulse never stretches
      flags   <= sel_fire;
      if (sel_fire) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    data_valid = enable && (state_q != IDLE);
    load_ready = enable && ((state_q == IDLE) || ((state_q == S_SEL) && data_ready));
    load_fire  = load_valid && load_ready;
    out_fire   = data_valid && data_ready;
    sel_fire   = out_fire && (state_q == S_SEL);
    case (state_q)
      IDLE:  if (load_fire) state_d = S_LOW;
      S_LOW: if (out_fire)  state_d = S_HI;
      S_HI:  if (out_fire)  state_d = S_SEL;
      S_SEL: if (out_fire)  state_d = load_fire ? S_LOW : IDLE;
      default:              state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/fir_serializer.sv
// rtl/fir_serializer.sv - captures a 3-word frame and emits it one word per transfer
module fir_serializer
  import fir_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  fir_serializer_if.slave   bus,
  output logic              flags,
  output logic [7:0]        frame_cnt
);

  state_t           state;
  logic             load_fire;
  logic [WIDTH-1:0] low_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] sel_q;

  fir_serializer_ctrl u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (bus.load_valid),
    .data_ready (bus.data_ready),
    .state      (state),
    .load_ready (bus.load_ready),
    .load_fire  (load_fire),
    .data_valid (bus.data_valid),
    .flags      (flags),
    .frame_cnt  (frame_cnt)
  );

  // Holding registers only change on an accepted load, so a stalled frame is never overwritten
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      low_q <= '0;
      hi_q  <= '0;
      sel_q <= '0;
    end else if (load_fire) begin
      low_q <= bus.Low_data_in;
      hi_q  <= bus.Hi_data_in;
      sel_q <= bus.select_in;
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (state)
      S_LOW:   bus.data_out = low_q;
      S_HI:    bus.data_out = hi_q;
      S_SEL:   bus.data_out = sel_q;
      default: bus.data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_fir_serializer.sv
// tb/tb_fir_serializer.sv - directed self-checking bench for fir_serializer
module tb_fir_serializer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       flags;
  logic [7:0] frame_cnt;
  int         checks;
  int         errors;
  int         flag_pulses;
  logic       count_en;

  fir_serializer_if #(.WIDTH(32)) bus ();

  fir_serializer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .flags     (flags),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (count_en && flags) flag_pulses++;
  end

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] se);
    bus.Low_data_in = lo;
    bus.Hi_data_in  = hi;
    bus.select_in   = se;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset          = 1'b0;
    enable         = 1'b1;
    bus.load_valid = 1'b0;
    bus.data_ready = 1'b1;
    #1;
    chk_b("rst_valid", bus.data_valid, 1'b0);
    chk_w("rst_data", bus.data_out, 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; flag_pulses = 0; count_en = 1'b0;
    reset = 1'b0; enable = 1'b0;
    bus.load_valid = 1'b0; bus.data_ready = 1'b1;
    set_words(32'h0, 32'h0, 32'h0);

    // reset state
    #2;
    chk_b("rst_load_ready_en0", bus.load_ready, 1'b0);
    enable = 1'b1;
    #1;
    chk_b("rst_load_ready_en1", bus.load_ready, 1'b1);
    chk_w("rst_data_out", bus.data_out, 32'h0);
    chk_b("rst_data_valid", bus.data_valid, 1'b0);
    chk_b("rst_flags", flags, 1'b0);
    chk_w("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // single frame
    do_reset();
    set_words(32'h11, 32'h22, 32'h33);
    bus.load_valid = 1'b1;
    #1 chk_b("t1_load_ready_idle", bus.load_ready, 1'b1);
    cyc(); bus.load_valid = 1'b0; #1;
    chk_w("t1_w0", bus.data_out, 32'h11);
    chk_b("t1_v0", bus.data_valid, 1'b1);
    chk_b("t1_lr_low", bus.load_ready, 1'b0);
    cyc(); chk_w("t1_w1", bus.data_out, 32'h22);
    cyc(); chk_w("t1_w2", bus.data_out, 32'h33);
    chk_b("t1_lr_sel", bus.load_ready, 1'b1);
    cyc();
    chk_b("t1_flags", flags, 1'b1);
    chk_w("t1_cnt", 32'(frame_cnt), 32'd1);
    chk_b("t1_idle_valid", bus.data_valid, 1'b0);
    chk_w("t1_idle_data", bus.data_out, 32'h0);
    cyc(); chk_b("t1_flags_clear", flags, 1'b0);

    // back-to-back frames
    do_reset();
    set_words(32'h1, 32'h2, 32'h3);
    bus.load_valid = 1'b1;
    cyc(); set_words(32'hA, 32'hB, 32'hC); #1;
    chk_w("t2_w0", bus.data_out, 32'h1);
    cyc(); chk_w("t2_w1", bus.data_out, 32'h2);
    cyc(); chk_w("t2_w2", bus.data_out, 32'h3);
    chk_b("t2_lr", bus.load_ready, 1'b1);
    cyc(); bus.load_valid = 1'b0; #1;
    chk_w("t2_w3", bus.data_out, 32'hA);
    chk_b("t2_v3", bus.data_valid, 1'b1);
    chk_b("t2_flags1", flags, 1'b1);
    chk_w("t2_cnt1", 32'(frame_cnt), 32'd1);
    cyc(); chk_w("t2_w4", bus.data_out, 32'hB);
    chk_b("t2_flags_off", flags, 1'b0);
    cyc(); chk_w("t2_w5", bus.data_out, 32'hC);
    cyc();
    chk_b("t2_flags2", flags, 1'b1);
    chk_w("t2_cnt2", 32'(frame_cnt), 32'd2);
    chk_b("t2_idle", bus.data_valid, 1'b0);

    // downstream stall in S_HI, with a competing frame offered
    do_reset();
    set_words(32'h11, 32'h22, 32'h33);
    bus.load_valid = 1'b1;
    cyc(); bus.load_valid = 1'b0; #1;
    chk_w("t3_w0", bus.data_out, 32'h11);
    cyc();
    bus.data_ready = 1'b0;
    set_words(32'h99, 32'h98, 32'h97);
    bus.load_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_w("t3_hold_data", bus.data_out, 32'h22);
      chk_b("t3_hold_valid", bus.data_valid, 1'b1);
      chk_b("t3_hold_lr", bus.load_ready, 1'b0);
    end
    bus.load_valid = 1'b0;
    bus.data_ready = 1'b1;
    cyc(); chk_w("t3_resume", bus.data_out, 32'h33);
    cyc(); chk_w("t3_cnt", 32'(frame_cnt), 32'd1);

    // enable low in S_LOW
    do_reset();
    set_words(32'h11, 32'h22, 32'h33);
    bus.load_valid = 1'b1;
    cyc();
    bus.load_valid = 1'b0;
    enable = 1'b0;
    #1;
    chk_b("t4_valid_off", bus.data_valid, 1'b0);
    chk_b("t4_lr_off", bus.load_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_b("t4_frozen_valid", bus.data_valid, 1'b0);
      chk_w("t4_frozen_data", bus.data_out, 32'h11);
    end
    enable = 1'b1;
    #1;
    chk_b("t4_valid_on", bus.data_valid, 1'b1);
    chk_w("t4_w0", bus.data_out, 32'h11);
    cyc(); chk_w("t4_w1", bus.data_out, 32'h22);
    cyc(); chk_w("t4_w2", bus.data_out, 32'h33);
    cyc();
    chk_b("t4_flags", flags, 1'b1);
    chk_w("t4_cnt", 32'(frame_cnt), 32'd1);

    // reset in the middle of a frame
    do_reset();
    set_words(32'h11, 32'h22, 32'h33);
    bus.load_valid = 1'b1;
    cyc(); bus.load_valid = 1'b0;
    cyc(); chk_w("t5_pre", bus.data_out, 32'h22);
    reset = 1'b0;
    #1;
    chk_b("t5_async_valid", bus.data_valid, 1'b0);
    chk_w("t5_async_data", bus.data_out, 32'h0);
    reset = 1'b1;
    set_words(32'h44, 32'h55, 32'h66);
    bus.load_valid = 1'b1;
    cyc(); bus.load_valid = 1'b0; #1;
    chk_b("t5_no_flags", flags, 1'b0);
    chk_w("t5_cnt0", 32'(frame_cnt), 32'd0);
    chk_w("t5_w0", bus.data_out, 32'h44);
    cyc(); chk_w("t5_w1", bus.data_out, 32'h55);
    cyc(); chk_w("t5_w2", bus.data_out, 32'h66);
    cyc();
    chk_b("t5_flags", flags, 1'b1);
    chk_w("t5_cnt1", 32'(frame_cnt), 32'd1);

    // 256 back-to-back frames wrap the counter
    do_reset();
    flag_pulses = 0;
    count_en = 1'b1;
    set_words(32'h5, 32'h6, 32'h7);
    bus.load_valid = 1'b1;
    repeat (768) cyc();
    chk_w("t6_cnt_255", 32'(frame_cnt), 32'd255);
    bus.load_valid = 1'b0;
    cyc();
    chk_b("t6_last_flags", flags, 1'b1);
    chk_w("t6_cnt_wrap", 32'(frame_cnt), 32'd0);
    cyc();
    chk_w("t6_pulses", 32'(flag_pulses), 32'd256);
    chk_b("t6_idle", bus.data_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
